// File: rtl/ipsmacge_pkg.sv
// Constants and types shared by the GE MAC transmit request-wait tracker and the timeout scanner.
package ipsmacge_pkg;

    localparam int IDBIT   = 8;
    localparam int WAITBIT = 256;
    localparam int RTRYBIT = 2;
    localparam logic [RTRYBIT-1:0] MAXRTRY = 2'd3;

    typedef logic [IDBIT-1:0]   id_t;
    typedef logic [RTRYBIT-1:0] rtry_t;

    // Outcome of a timeout pulse once it has been qualified against the wait bit.
    typedef enum logic [1:0] {
        TO_NONE,
        TO_RETRY,
        TO_GIVEUP,
        TO_OVERFLOW
    } to_action_e;

endpackage

// File: rtl/ipsmacge_txreqwait_if.sv
// Issue/ack/timeout inputs and retransmit/give-up outputs of the request-wait tracker.
interface ipsmacge_txreqwait_if #(
    parameter int IDBIT   = ipsmacge_pkg::IDBIT,
    parameter int WAITBIT = ipsmacge_pkg::WAITBIT
);
    logic               upact;
    logic               issvld;
    logic [IDBIT-1:0]   issid;
    logic               issrtx;
    logic               ackvld;
    logic [IDBIT-1:0]   ackid;
    logic               timeout;
    logic [IDBIT-1:0]   idtimeo;
    logic [WAITBIT-1:0] reqwait;
    logic               rtxvld;
    logic [IDBIT-1:0]   rtxid;
    logic               rtxrdy;
    logic               giveup;
    logic [IDBIT-1:0]   gvid;
    logic               rtxovf;

    modport slave (
        input  upact, issvld, issid, issrtx, ackvld, ackid, timeout, idtimeo, rtxrdy,
        output reqwait, rtxvld, rtxid, giveup, gvid, rtxovf
    );

    modport master (
        output upact, issvld, issid, issrtx, ackvld, ackid, timeout, idtimeo, rtxrdy,
        input  reqwait, rtxvld, rtxid, giveup, gvid, rtxovf
    );

endinterface

// File: rtl/ipsmacge_txrtxfifo.sv
// Show-ahead synchronous FIFO holding ids queued for retransmission.
module ipsmacge_txrtxfifo #(
    parameter int DEPTH = 16,
    parameter int ABIT  = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] pushid,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] headid
);
    import ipsmacge_pkg::*;

    logic [DW-1:0] r_mem [DEPTH];
    logic [ABIT:0] r_wr_ptr_reg;
    logic [ABIT:0] r_rd_ptr_reg;
    logic          w_full;
    logic          w_empty;
    logic          w_push_en;
    logic          w_pop_en;

    // The extra MSB tells full from empty when the wrapped indices coincide.
    assign w_empty = (r_wr_ptr_reg == r_rd_ptr_reg);
    assign w_full  = (r_wr_ptr_reg[ABIT] != r_rd_ptr_reg[ABIT]) &&
                     (r_wr_ptr_reg[ABIT-1:0] == r_rd_ptr_reg[ABIT-1:0]);

    assign w_pop_en  = pop && !w_empty;
    assign w_push_en = push && (!w_full || w_pop_en);

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr_reg[ABIT-1:0]] <= pushid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr_reg <= '0;
            r_rd_ptr_reg <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr_reg <= r_wr_ptr_reg + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr_reg <= r_rd_ptr_reg + 1'b1;
            end
        end
    end

    assign full   = w_full;
    assign empty  = w_empty;
    // Forced to zero when empty so the head never exposes stale or unwritten storage.
    assign headid = w_empty ? '0 : r_mem[r_rd_ptr_reg[ABIT-1:0]];

endmodule

// File: rtl/ipsmacge_txreqwait.sv
// Per-id wait/retry tracking for the GE MAC transmit path, with retransmit queue and give-up reporting.
module ipsmacge_txreqwait #(
    parameter int IDBIT   = ipsmacge_pkg::IDBIT,
    parameter int WAITBIT = ipsmacge_pkg::WAITBIT,
    parameter int RTRYBIT = ipsmacge_pkg::RTRYBIT,
    parameter logic [RTRYBIT-1:0] MAXRTRY = ipsmacge_pkg::MAXRTRY,
    parameter int RTXDEPTH = 16,
    parameter int RTXABIT  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ipsmacge_txreqwait_if.slave    bus
);
    import ipsmacge_pkg::*;

    logic [WAITBIT-1:0] w_reqwait;
    logic [RTRYBIT-1:0] w_cnt_arr [WAITBIT];

    logic               w_to_wait;
    logic [RTRYBIT-1:0] w_to_cnt;
    logic               w_to_iss;
    logic               w_to_ack;
    logic               w_to_hit;
    logic               w_slot_free;
    to_action_e         w_to_act;
    logic               w_push;
    logic               w_pop;
    logic               w_giveup_next;
    logic               w_ovf_set;

    logic               w_full;
    logic               w_empty;
    logic [IDBIT-1:0]   w_headid;

    logic               r_giveup_reg;
    logic [IDBIT-1:0]   r_gvid_reg;
    logic               r_rtxovf_reg;

    // A timeout only counts if the id is still waiting and no issue or ack for it lands this cycle.
    assign w_to_wait = w_reqwait[bus.idtimeo];
    assign w_to_cnt  = w_cnt_arr[bus.idtimeo];
    assign w_to_iss  = bus.issvld && (bus.issid == bus.idtimeo);
    assign w_to_ack  = bus.ackvld && (bus.ackid == bus.idtimeo);
    assign w_to_hit  = bus.upact && bus.timeout && w_to_wait && !w_to_iss && !w_to_ack;

    assign w_pop       = bus.upact && !w_empty && bus.rtxrdy;
    assign w_slot_free = !w_full || w_pop;

    always_comb begin
        w_to_act = TO_NONE;
        if (w_to_hit) begin
            if (w_to_cnt >= MAXRTRY) begin
                w_to_act = TO_GIVEUP;
            end else if (w_slot_free) begin
                w_to_act = TO_RETRY;
            end else begin
                w_to_act = TO_OVERFLOW;
            end
        end
    end

    assign w_push        = (w_to_act == TO_RETRY);
    assign w_giveup_next = (w_to_act == TO_GIVEUP) || (w_to_act == TO_OVERFLOW);
    assign w_ovf_set     = (w_to_act == TO_OVERFLOW);

    genvar gi;
    generate
        for (gi = 0; gi < WAITBIT; gi++) begin : g_id
            logic               w_iss;
            logic               w_ack;
            logic               w_to;
            logic               r_wait_reg;
            logic [RTRYBIT-1:0] r_cnt_reg;

            assign w_iss = bus.issvld && (bus.issid == IDBIT'(gi));
            assign w_ack = bus.ackvld && (bus.ackid == IDBIT'(gi));
            assign w_to  = w_to_hit && (bus.idtimeo == IDBIT'(gi));

            // Issue beats ack beats timeout; a timeout that is not queued restarts the count.
            always_ff @(posedge clk) begin
                if (rst || !bus.upact) begin
                    r_wait_reg <= 1'b0;
                    r_cnt_reg  <= '0;
                end else if (w_iss) begin
                    r_wait_reg <= 1'b1;
                    if (!bus.issrtx) begin
                        r_cnt_reg <= '0;
                    end
                end else if (w_ack) begin
                    r_wait_reg <= 1'b0;
                    r_cnt_reg  <= '0;
                end else if (w_to) begin
                    r_wait_reg <= 1'b0;
                    r_cnt_reg  <= w_push ? (r_cnt_reg + 1'b1) : '0;
                end
            end

            assign w_reqwait[gi] = r_wait_reg;
            assign w_cnt_arr[gi] = r_cnt_reg;
        end
    endgenerate

    ipsmacge_txrtxfifo #(
        .DEPTH (RTXDEPTH),
        .ABIT  (RTXABIT),
        .DW    (IDBIT)
    ) u_rtxfifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (!bus.upact),
        .push   (w_push),
        .pushid (bus.idtimeo),
        .pop    (w_pop),
        .full   (w_full),
        .empty  (w_empty),
        .headid (w_headid)
    );

    always_ff @(posedge clk) begin
        if (rst || !bus.upact) begin
            r_giveup_reg <= 1'b0;
        end else begin
            r_giveup_reg <= w_giveup_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gvid_reg <= '0;
        end else if (w_giveup_next) begin
            r_gvid_reg <= bus.idtimeo;
        end
    end

    // Overflow is sticky across port deactivation; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rtxovf_reg <= 1'b0;
        end else if (w_ovf_set) begin
            r_rtxovf_reg <= 1'b1;
        end
    end

    assign bus.reqwait = w_reqwait;
    assign bus.rtxvld  = !w_empty;
    assign bus.rtxid   = w_headid;
    assign bus.giveup  = r_giveup_reg;
    assign bus.gvid    = r_gvid_reg;
    assign bus.rtxovf  = r_rtxovf_reg;

endmodule

// File: tb/tb_ipsmacge_txreqwait.sv
// Directed vector bench for the transmit request-wait tracker.
module tb_ipsmacge_txreqwait;
    import ipsmacge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipsmacge_txreqwait_if bus ();

    ipsmacge_txreqwait dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       upact;
        logic       issvld;
        logic [7:0] issid;
        logic       issrtx;
        logic       ackvld;
        logic [7:0] ackid;
        logic       timeout;
        logic [7:0] idtimeo;
        logic       rtxrdy;
        int         chk;
        logic       exp_bit;
        logic       exp_vld;
        logic [7:0] exp_id;
        logic       exp_gv;
        logic [7:0] exp_gvid;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic up, input logic iv, input logic [7:0] iid, input logic ir,
                                input logic av, input logic [7:0] aid, input logic to, input logic [7:0] tid,
                                input logic rdy, input int chk, input logic eb, input logic ev,
                                input logic [7:0] eid, input logic egv, input logic [7:0] egvid,
                                input logic eovf);
        vec_t v;
        v.upact = up;   v.issvld = iv;  v.issid = iid;  v.issrtx = ir;
        v.ackvld = av;  v.ackid = aid;  v.timeout = to; v.idtimeo = tid;
        v.rtxrdy = rdy; v.chk = chk;    v.exp_bit = eb; v.exp_vld = ev;
        v.exp_id = eid; v.exp_gv = egv; v.exp_gvid = egvid; v.exp_ovf = eovf;
        return v;
    endfunction

    task automatic drive(input logic up, input logic iv, input logic [7:0] iid, input logic ir,
                         input logic av, input logic [7:0] aid, input logic to, input logic [7:0] tid,
                         input logic rdy);
        bus.upact   = up;
        bus.issvld  = iv;
        bus.issid   = iid;
        bus.issrtx  = ir;
        bus.ackvld  = av;
        bus.ackid   = aid;
        bus.timeout = to;
        bus.idtimeo = tid;
        bus.rtxrdy  = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic eb, input logic ev,
                         input logic [7:0] eid, input logic egv, input logic [7:0] egvid,
                         input logic eovf);
        int bad;
        bad = 0;
        n_vec++;
        if (bus.reqwait[idx] !== eb) begin
            $display("FAIL %s reqwait[%0d]: got %b want %b", tag, idx, bus.reqwait[idx], eb);
            bad++;
        end
        if (bus.rtxvld !== ev) begin
            $display("FAIL %s rtxvld: got %b want %b", tag, bus.rtxvld, ev);
            bad++;
        end
        if (ev && (bus.rtxid !== eid)) begin
            $display("FAIL %s rtxid: got %0d want %0d", tag, bus.rtxid, eid);
            bad++;
        end
        if (bus.giveup !== egv) begin
            $display("FAIL %s giveup: got %b want %b", tag, bus.giveup, egv);
            bad++;
        end
        if (egv && (bus.gvid !== egvid)) begin
            $display("FAIL %s gvid: got %0d want %0d", tag, bus.gvid, egvid);
            bad++;
        end
        if (bus.rtxovf !== eovf) begin
            $display("FAIL %s rtxovf: got %b want %b", tag, bus.rtxovf, eovf);
            bad++;
        end
        n_err += bad;
        $display("vec %0d %s id=%0d rw=%b vld=%b rtxid=%0d gv=%b gvid=%0d ovf=%b : %s",
                 n_vec, tag, idx, bus.reqwait[idx], bus.rtxvld, bus.rtxid, bus.giveup,
                 bus.gvid, bus.rtxovf, (bad == 0) ? "ok" : "bad");
    endtask

    task automatic check_idle(input string tag, input logic chk_gvid, input logic eovf);
        int bad;
        bad = 0;
        n_vec++;
        if (bus.reqwait !== '0) begin
            $display("FAIL %s reqwait: got %h want 0", tag, bus.reqwait);
            bad++;
        end
        if (bus.rtxvld !== 1'b0 || bus.rtxid !== 8'd0) begin
            $display("FAIL %s rtxvld/rtxid: got %b/%0d want 0/0", tag, bus.rtxvld, bus.rtxid);
            bad++;
        end
        if (bus.giveup !== 1'b0) begin
            $display("FAIL %s giveup: got %b want 0", tag, bus.giveup);
            bad++;
        end
        if (chk_gvid && (bus.gvid !== 8'd0)) begin
            $display("FAIL %s gvid: got %0d want 0", tag, bus.gvid);
            bad++;
        end
        if (bus.rtxovf !== eovf) begin
            $display("FAIL %s rtxovf: got %b want %b", tag, bus.rtxovf, eovf);
            bad++;
        end
        n_err += bad;
        $display("vec %0d %s all-idle ovf=%b : %s", n_vec, tag, bus.rtxovf, (bad == 0) ? "ok" : "bad");
    endtask

    initial begin
        // id 5: three retransmissions then give-up on the fourth timeout
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 0,   5,0,0,  0,0,0,0));
        tbl.push_back(mk(1,1,  5,0, 0,  0, 0,  0, 0,   5,1,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 1,  5, 0,   5,0,1,  5,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 1,   5,0,0,  0,0,0,0));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(1,1,  5,1, 0,  0, 0,  0, 0,   5,1,0,  0,0,0,0));
            tbl.push_back(mk(1,0,  0,0, 0,  0, 1,  5, 0,   5,0,1,  5,0,0,0));
            tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 1,   5,0,0,  0,0,0,0));
        end
        tbl.push_back(mk(1,1,  5,1, 0,  0, 0,  0, 0,   5,1,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 1,  5, 0,   5,0,0,  0,1,5,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 0,   5,0,0,  0,0,0,0));
        // id 9: issue+ack keeps bit set, then ack+timeout clears without retry
        tbl.push_back(mk(1,1,  9,0, 1,  9, 0,  0, 0,   9,1,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 1,  9, 1,  9, 0,   9,0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 0,   9,0,0,  0,0,0,0));
        // timeout on an id that is not waiting
        tbl.push_back(mk(1,0,  0,0, 0,  0, 1,200, 0, 200,0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 0, 200,0,0,  0,0,0,0));
        // edge ids 0/255, issue wins over ack and timeout, independent ids
        tbl.push_back(mk(1,1,255,0, 0,  0, 0,  0, 0, 255,1,0,  0,0,0,0));
        tbl.push_back(mk(1,1,  0,0, 1,  0, 0,  0, 0,   0,1,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 0,  0, 0,  0, 0, 255,1,0,  0,0,0,0));
        tbl.push_back(mk(1,1,  7,0, 1,255, 0,  0, 0, 255,0,0,  0,0,0,0));
        tbl.push_back(mk(1,1,  7,0, 0,  0, 1,  7, 0,   7,1,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 1,  0, 0,  0, 0,   0,0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,  0,0, 1,  7, 0,  0, 0,   7,0,0,  0,0,0,0));

        rst = 1'b1;
        drive(1,0,0,0,0,0,0,0,0);
        step();
        step();
        check_idle("reset", 1'b1, 1'b0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].upact, tbl[k].issvld, tbl[k].issid, tbl[k].issrtx, tbl[k].ackvld,
                  tbl[k].ackid, tbl[k].timeout, tbl[k].idtimeo, tbl[k].rtxrdy);
            step();
            check($sformatf("tbl%0d", k), tbl[k].chk, tbl[k].exp_bit, tbl[k].exp_vld,
                  tbl[k].exp_id, tbl[k].exp_gv, tbl[k].exp_gvid, tbl[k].exp_ovf);
        end

        // FIFO fill: pass 0 overflows the 17th id, pass 1 accepts it thanks to a same-cycle pop
        for (int pass = 0; pass < 2; pass++) begin
            logic       ovf_before;
            logic [7:0] head;
            ovf_before = (pass == 1);
            for (int i = 0; i < 16; i++) begin
                drive(1,1,8'(100+i),0,0,0,0,0,0);
                step();
                check("fill_iss", 100+i, 1, 0, 0, 0, 0, ovf_before);
            end
            for (int i = 0; i < 16; i++) begin
                drive(1,0,0,0,0,0,1,8'(100+i),0);
                step();
                check("fill_to", 100+i, 0, 1, 8'd100, 0, 0, ovf_before);
            end
            drive(1,1,8'd116,0,0,0,0,0,0);
            step();
            check("iss116", 116, 1, 1, 8'd100, 0, 0, ovf_before);
            if (pass == 0) begin
                drive(1,0,0,0,0,0,1,8'd116,0);
                step();
                check("ovf116", 116, 0, 1, 8'd100, 1, 8'd116, 1);
                for (int i = 0; i < 16; i++) begin
                    drive(1,0,0,0,0,0,0,0,1);
                    step();
                    head = 8'(101+i);
                    check("drain0", 116, 0, (i < 15), head, 0, 0, 1);
                end
            end else begin
                drive(1,0,0,0,0,0,1,8'd116,1);
                step();
                check("pushpop116", 116, 0, 1, 8'd101, 0, 0, 1);
                for (int i = 0; i < 16; i++) begin
                    drive(1,0,0,0,0,0,0,0,1);
                    step();
                    head = 8'(102+i);
                    check("drain1", 116, 0, (i < 15), head, 0, 0, 1);
                end
            end
        end

        // upact low mid-traffic, then reset
        drive(1,1,8'd50,0,0,0,0,0,0);
        step();
        drive(1,0,0,0,0,0,1,8'd50,0);
        step();
        check("to50", 50, 0, 1, 8'd50, 0, 0, 1);
        drive(1,1,8'd60,0,0,0,0,0,0);
        step();
        check("iss60", 60, 1, 1, 8'd50, 0, 0, 1);
        drive(0,1,8'd70,0,0,0,1,8'd60,0);
        step();
        check_idle("upact_low", 1'b0, 1'b1);
        drive(1,0,0,0,0,0,0,0,0);
        step();
        check("after_upact", 60, 0, 0, 0, 0, 0, 1);
        drive(1,1,8'd80,0,0,0,0,0,0);
        step();
        check("iss80", 80, 1, 0, 0, 0, 0, 1);
        rst = 1'b1;
        drive(1,1,8'd81,0,0,0,1,8'd80,0);
        step();
        check_idle("rst_mid", 1'b1, 1'b0);
        rst = 1'b0;
        drive(1,0,0,0,0,0,0,0,0);
        step();
        check_idle("post_rst", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
